// File: rtl/shift_reg_chain.sv
// shift_reg_chain: serial driver for a daisy-chain of 74HC595-style registers with SRCLK divider, RCLK latch and sticky OE_n.
module shift_reg_chain #(
  parameter int NUM_REGS  = 2,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [8*NUM_REGS-1:0]   i_Data,
  input  logic                    i_Enable,
  output logic                    o_Ready,
  output logic                    o_SRCLK,
  output logic                    o_SER,
  output logic                    o_RCLK,
  output logic                    o_OE_n
);
  localparam int WIDTH = 8*NUM_REGS;
  localparam int DW    = $clog2(CLK_DIV+1);
  localparam int CW    = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  state_t            state, state_n;
  logic [DW-1:0]     div, div_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [WIDTH-1:0]  sh, sh_n, sh_adv;
  logic              live, tick;
  logic              ready_n, srclk_n, ser_n, rclk_n, oe_n_n;
  always_comb begin
    tick    = div == DW'(CLK_DIV-1);
    sh_adv  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    state_n = state;
    div_n   = (state == IDLE || tick) ? '0 : div + 1'b1;
    cnt_n   = cnt;
    sh_n    = sh;
    ready_n = o_Ready;
    srclk_n = o_SRCLK;
    ser_n   = o_SER;
    rclk_n  = o_RCLK;
    oe_n_n  = o_OE_n;
    case (state)
      IDLE: if (live && i_Enable) begin
        state_n = SHIFT_LO;
        sh_n    = i_Data;
        cnt_n   = CW'(WIDTH);
        ser_n   = MSB_FIRST ? i_Data[WIDTH-1] : i_Data[0];
        ready_n = 1'b0;
      end
      SHIFT_LO: if (tick) begin
        state_n = SHIFT_HI;
        srclk_n = 1'b1;
      end
      SHIFT_HI: if (tick) begin
        cnt_n   = cnt - 1'b1;
        srclk_n = 1'b0;
        state_n = (cnt != CW'(1)) ? SHIFT_LO : LATCH;
        rclk_n  = cnt == CW'(1);
        sh_n    = (cnt != CW'(1)) ? sh_adv : sh;
        ser_n   = (cnt != CW'(1)) ? (MSB_FIRST ? sh_adv[WIDTH-1] : sh_adv[0]) : o_SER;
      end
      LATCH: if (tick) begin
        state_n = IDLE;
        rclk_n  = 1'b0;
        ready_n = 1'b1;
        oe_n_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  // live holds off acceptance on the edge where reset is released
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      div     <= '0;
      cnt     <= '0;
      sh      <= '0;
      live    <= 1'b0;
      o_Ready <= 1'b1;
      o_SRCLK <= 1'b0;
      o_SER   <= 1'b0;
      o_RCLK  <= 1'b0;
      o_OE_n  <= 1'b1;
    end else begin
      state   <= state_n;
      div     <= div_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      live    <= 1'b1;
      o_Ready <= ready_n;
      o_SRCLK <= srclk_n;
      o_SER   <= ser_n;
      o_RCLK  <= rclk_n;
      o_OE_n  <= oe_n_n;
    end
  end
endmodule

// File: tb/tb_shift_reg_chain.sv
// tb_shift_reg_chain: scoreboard bench with a 595-chain model per DUT instance.
module tb_shift_reg_chain;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] data_a = '0;
  logic [7:0]  data_b = '0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic a_ready, a_srclk, a_ser, a_rclk, a_oe_n;
  logic b_ready, b_srclk, b_ser, b_rclk, b_oe_n;
  int tests = 0, fails = 0;
  logic [15:0] exp_a[$];
  logic [7:0]  exp_b[$];
  always #5 clk = ~clk;
  shift_reg_chain dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_Data(data_a), .i_Enable(en_a),
    .o_Ready(a_ready), .o_SRCLK(a_srclk), .o_SER(a_ser), .o_RCLK(a_rclk), .o_OE_n(a_oe_n)
  );
  shift_reg_chain #(.NUM_REGS(1), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_Data(data_b), .i_Enable(en_b),
    .o_Ready(b_ready), .o_SRCLK(b_srclk), .o_SER(b_ser), .o_RCLK(b_rclk), .o_OE_n(b_oe_n)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor A: 16-bit MSB-first chain model, sampled on falling clk edges
  logic pa_srclk = 0, pa_rclk = 0, pa_ready = 1, pa_ser = 0;
  logic [15:0] a_chain = '0, a_latched = '0;
  int a_low = 0, a_rise = 0, a_rw = 0, a_total = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_low = 0; a_rise = 0; a_rw = 0;
    end else begin
      if (a_srclk) check("ser_hold_a", a_ser, pa_ser);
      if (a_srclk && !pa_srclk) begin a_chain = {a_chain[14:0], a_ser}; a_rise++; end
      if (a_rclk) a_rw++;
      if (a_rclk && !pa_rclk) begin a_latched = a_chain; check("srclk_low_at_rclk_a", a_srclk, 0); end
      if (!a_rclk && pa_rclk) begin
        tests++;
        if (exp_a.size() == 0) begin fails++; $display("FAIL latch_a: got %h expected no latch", a_latched); end
        else begin
          tests--;
          check("latch_a", a_latched, exp_a.pop_front());
        end
        check("srclk_edges_a", a_rise, 16);
        check("rclk_width_a", a_rw, 4);
        check("oe_n_after_latch_a", a_oe_n, 0);
        a_total++; a_rise = 0; a_rw = 0;
      end
      if (!a_ready) a_low++;
      if (a_ready && !pa_ready) begin check("ready_low_a", a_low, 132); a_low = 0; end
    end
    pa_srclk = a_srclk; pa_rclk = a_rclk; pa_ready = a_ready; pa_ser = a_ser;
  end
  // monitor B: 8-bit LSB-first chain model, word rebuilt in shift order
  logic pb_srclk = 0, pb_rclk = 0, pb_ready = 1, pb_ser = 0;
  logic [7:0] b_chain = '0, b_latched = '0;
  int b_low = 0, b_rise = 0, b_hi = 0, b_rw = 0, b_total = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_low = 0; b_rise = 0; b_hi = 0; b_rw = 0;
    end else begin
      if (b_srclk) begin check("ser_hold_b", b_ser, pb_ser); b_hi++; end
      if (b_srclk && !pb_srclk) begin b_chain = {b_ser, b_chain[7:1]}; b_rise++; end
      if (b_rclk) b_rw++;
      if (b_rclk && !pb_rclk) b_latched = b_chain;
      if (!b_rclk && pb_rclk) begin
        tests++;
        if (exp_b.size() == 0) begin fails++; $display("FAIL latch_b: got %h expected no latch", b_latched); end
        else begin
          tests--;
          check("latch_b", b_latched, exp_b.pop_front());
        end
        check("srclk_edges_b", b_rise, 8);
        check("srclk_high_cycles_b", b_hi, 8);
        check("rclk_width_b", b_rw, 1);
        b_total++; b_rise = 0; b_hi = 0; b_rw = 0;
      end
      if (!b_ready) b_low++;
      if (b_ready && !pb_ready) begin check("ready_low_b", b_low, 17); b_low = 0; end
    end
    pb_srclk = b_srclk; pb_rclk = b_rclk; pb_ready = b_ready; pb_ser = b_ser;
  end
  task automatic wait_ready_a();
    for (int n = 0; n < 2000 && !a_ready; n++) @(negedge clk);
    check("timeout_a", a_ready, 1);
  endtask
  task automatic send_a(input logic [15:0] d);
    data_a = d; en_a = 1'b1; exp_a.push_back(d);
    @(negedge clk);
    en_a = 1'b0;
    wait_ready_a();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", a_ready, 1);
    check("rst_srclk", a_srclk, 0);
    check("rst_ser", a_ser, 0);
    check("rst_rclk", a_rclk, 0);
    check("rst_oe_n", a_oe_n, 1);
    rst_n = 1'b1; data_a = 16'hA5C3; en_a = 1'b1; exp_a.push_back(16'hA5C3);
    @(negedge clk);
    check("enable_at_release_ignored", a_ready, 1);
    @(negedge clk);
    check("accept_after_release", a_ready, 0);
    check("oe_n_blank_before_latch", a_oe_n, 1);
    en_a = 1'b0;
    wait_ready_a();
    data_a = 16'h0000; en_a = 1'b1; exp_a.push_back(16'h0000);
    @(negedge clk);
    en_a = 1'b0;
    repeat (10) @(negedge clk);
    data_a = 16'hFFFF; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    wait_ready_a();
    data_a = 16'h1234; en_a = 1'b1; exp_a.push_back(16'h1234); exp_a.push_back(16'h5678);
    @(negedge clk);
    repeat (10) @(negedge clk);
    data_a = 16'h5678;
    for (int n = 0; n < 2000 && !a_ready; n++) @(negedge clk);
    @(negedge clk);
    check("b2b_one_idle_cycle", a_ready, 0);
    en_a = 1'b0;
    wait_ready_a();
    data_a = 16'hBEEF; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    begin
      int r = 0;
      logic p = 1'b0;
      for (int n = 0; n < 500 && r < 5; n++) begin
        @(negedge clk);
        if (a_srclk && !p) r++;
        p = a_srclk;
      end
      check("five_srclk_edges", r, 5);
    end
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ready", a_ready, 1);
    check("async_rst_srclk", a_srclk, 0);
    check("async_rst_ser", a_ser, 0);
    check("async_rst_rclk", a_rclk, 0);
    check("async_rst_oe_n", a_oe_n, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("oe_n_blank_after_rst", a_oe_n, 1);
    send_a(16'h0F0F);
    check("oe_n_after_recovery", a_oe_n, 0);
    data_b = 8'h01; en_b = 1'b1; exp_b.push_back(8'h01);
    @(negedge clk);
    en_b = 1'b0;
    for (int n = 0; n < 500 && !b_ready; n++) @(negedge clk);
    check("timeout_b", b_ready, 1);
    check("oe_n_b", b_oe_n, 0);
    repeat (3) @(negedge clk);
    check("rclk_count_a", a_total, 5);
    check("queue_empty_a", exp_a.size(), 0);
    check("rclk_count_b", b_total, 1);
    check("queue_empty_b", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
